// File: rtl/uart_tx_sched_if.sv
// Handshake bundle between the two byte requesters, the scheduler and the UART TX engine.
// The master side is the sources plus the transmitter; the slave side is the scheduler.
interface uart_tx_sched_if;
    logic [7:0] req0_data;
    logic       req0_valid;
    logic       req0_ready;
    logic [7:0] req1_data;
    logic       req1_valid;
    logic       req1_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_busy;
    logic [1:0] grant;
    logic       busy;

    modport master (
        output req0_data, req0_valid, req1_data, req1_valid, tx_ready, tx_busy,
        input  req0_ready, req1_ready, tx_data, tx_valid, grant, busy
    );

    modport slave (
        input  req0_data, req0_valid, req1_data, req1_valid, tx_ready, tx_busy,
        output req0_ready, req1_ready, tx_data, tx_valid, grant, busy
    );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART TX engine between two single-entry byte requesters,
// with a post-frame idle gap counted in bit-rate enable ticks.
module uart_tx_sched #(
    parameter int unsigned GAP_TICKS = 2,
    parameter int unsigned CNT_W     = 8
) (
    input logic           clk_i,
    input logic           resetn_i,
    input logic           clk_en_i,
    uart_tx_sched_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StSend, StWaitDone, StGap} state_e;

    localparam logic [CNT_W-1:0] GapLast = CNT_W'(GAP_TICKS - 1);

    state_e           state_q, state_d;
    logic             hold0_valid_q, hold0_valid_d;
    logic             hold1_valid_q, hold1_valid_d;
    logic [7:0]       hold0_data_q, hold0_data_d;
    logic [7:0]       hold1_data_q, hold1_data_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic [1:0]       grant_q, grant_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pick1;

    // last_q = 1 means port 1 owned the previous frame, so port 0 is preferred next.
    assign pick1 = hold1_valid_q & (~hold0_valid_q | ~last_q);

    always_comb begin
        state_d       = state_q;
        hold0_valid_d = hold0_valid_q;
        hold1_valid_d = hold1_valid_q;
        hold0_data_d  = hold0_data_q;
        hold1_data_d  = hold1_data_q;
        tx_data_d     = tx_data_q;
        grant_d       = grant_q;
        last_d        = last_q;
        cnt_d         = cnt_q;

        if (bus.req0_valid && !hold0_valid_q) begin
            hold0_valid_d = 1'b1;
            hold0_data_d  = bus.req0_data;
        end
        if (bus.req1_valid && !hold1_valid_q) begin
            hold1_valid_d = 1'b1;
            hold1_data_d  = bus.req1_data;
        end

        unique case (state_q)
            StIdle: begin
                if (hold0_valid_q || hold1_valid_q) begin
                    tx_data_d = pick1 ? hold1_data_q : hold0_data_q;
                    grant_d   = pick1 ? 2'b10 : 2'b01;
                    state_d   = StSend;
                end
            end
            StSend: begin
                // A full holding register has ready low, so no load can collide with this drain.
                if (bus.tx_ready) begin
                    if (grant_q[0]) begin
                        hold0_valid_d = 1'b0;
                    end else begin
                        hold1_valid_d = 1'b0;
                    end
                    last_d  = grant_q[1];
                    state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                if (!bus.tx_busy) begin
                    grant_d = 2'b00;
                    cnt_d   = '0;
                    state_d = (GAP_TICKS == 0) ? StIdle : StGap;
                end
            end
            StGap: begin
                if (clk_en_i) begin
                    if (cnt_q == GapLast) begin
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state_q       <= StIdle;
            hold0_valid_q <= 1'b0;
            hold1_valid_q <= 1'b0;
            hold0_data_q  <= '0;
            hold1_data_q  <= '0;
            tx_data_q     <= '0;
            grant_q       <= 2'b00;
            last_q        <= 1'b1;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            hold0_valid_q <= hold0_valid_d;
            hold1_valid_q <= hold1_valid_d;
            hold0_data_q  <= hold0_data_d;
            hold1_data_q  <= hold1_data_d;
            tx_data_q     <= tx_data_d;
            grant_q       <= grant_d;
            last_q        <= last_d;
            cnt_q         <= cnt_d;
        end
    end

    assign bus.req0_ready = ~hold0_valid_q;
    assign bus.req1_ready = ~hold1_valid_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.tx_valid   = (state_q == StSend);
    assign bus.grant      = grant_q;
    assign bus.busy       = (state_q != StIdle);
endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: expected {grant, byte} pairs are queued by the stimulus
// and popped by a monitor at every TX handshake; timing and reset checks are made inline.
module tb_uart_tx_sched;
    logic clk;
    logic resetn;
    logic clk_en;
    int   div_cnt;
    int   n_cmp;
    int   n_fail;
    int   busy_len;
    logic [9:0] exp_q[$];
    logic [9:0] exp_e;

    uart_tx_sched_if bus ();
    uart_tx_sched_if bus0 ();

    uart_tx_sched #(.GAP_TICKS(2), .CNT_W(8)) dut (
        .clk_i(clk), .resetn_i(resetn), .clk_en_i(clk_en), .bus(bus)
    );

    uart_tx_sched #(.GAP_TICKS(0), .CNT_W(8)) dut0 (
        .clk_i(clk), .resetn_i(resetn), .clk_en_i(clk_en), .bus(bus0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Divisor 7: one enable pulse every 8 clocks.
    initial begin
        clk_en  = 1'b0;
        div_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            div_cnt = (div_cnt == 7) ? 0 : div_cnt + 1;
            clk_en  = (div_cnt == 7);
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: timed out", name);
    endtask

    // Transmitter model: busy for busy_len cycles starting the cycle after the handshake.
    initial begin
        bus.tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (resetn === 1'b1 && bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) begin
                @(posedge clk);
                #1 bus.tx_busy = 1'b1;
                repeat (busy_len) @(posedge clk);
                #1 bus.tx_busy = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (resetn === 1'b1 && bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_tx: got byte %0h grant %0b, none expected",
                             bus.tx_data, bus.grant);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("tx_byte", {24'd0, bus.tx_data}, {24'd0, exp_e[7:0]});
                    check("tx_grant", {30'd0, bus.grant}, {30'd0, exp_e[9:8]});
                end
            end
        end
    end

    task automatic send(input int port, input logic [7:0] d);
        int k;
        k = 0;
        if (port == 0) begin
            bus.req0_data  = d;
            bus.req0_valid = 1'b1;
            while (bus.req0_ready !== 1'b1 && k < 300) begin
                @(posedge clk);
                #1 k++;
            end
            @(posedge clk);
            #1 bus.req0_valid = 1'b0;
        end else begin
            bus.req1_data  = d;
            bus.req1_valid = 1'b1;
            while (bus.req1_ready !== 1'b1 && k < 300) begin
                @(posedge clk);
                #1 k++;
            end
            @(posedge clk);
            #1 bus.req1_valid = 1'b0;
        end
        if (k >= 300) fail_now("send_accept");
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        @(negedge clk);
        while (!(bus.busy === 1'b0 && exp_q.size() == 0) && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (k >= 400) fail_now(name);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input string name);
        @(posedge clk);
        #1 resetn = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        check({name, "_tx_valid"}, {31'd0, bus.tx_valid}, 32'd0);
        check({name, "_tx_data"}, {24'd0, bus.tx_data}, 32'd0);
        check({name, "_grant"}, {30'd0, bus.grant}, 32'd0);
        check({name, "_busy"}, {31'd0, bus.busy}, 32'd0);
        check({name, "_ready"}, {30'd0, bus.req1_ready, bus.req0_ready}, 32'd3);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   k;
        int   pulses;
        logic early;
        n_cmp          = 0;
        n_fail         = 0;
        busy_len       = 10;
        resetn         = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_data  = 8'h00;
        bus.req1_data  = 8'h00;
        bus.tx_ready   = 1'b1;
        bus0.req0_valid = 1'b0;
        bus0.req1_valid = 1'b0;
        bus0.req0_data  = 8'h00;
        bus0.req1_data  = 8'h00;
        bus0.tx_ready   = 1'b1;
        bus0.tx_busy    = 1'b0;
        repeat (2) @(posedge clk);
        apply_reset("reset");

        // Single byte: accept at N, valid at N+2 for one cycle, ready back at N+3.
        exp_q.push_back({2'b01, 8'hA5});
        send(0, 8'hA5);
        @(negedge clk);
        check("single_hold_ready", {31'd0, bus.req0_ready}, 32'd0);
        check("single_n1_valid", {31'd0, bus.tx_valid}, 32'd0);
        @(negedge clk);
        check("single_n2_valid", {31'd0, bus.tx_valid}, 32'd1);
        check("single_n2_data", {24'd0, bus.tx_data}, 32'hA5);
        check("single_n2_grant", {30'd0, bus.grant}, 32'd1);
        @(negedge clk);
        check("single_n3_valid", {31'd0, bus.tx_valid}, 32'd0);
        check("single_n3_ready", {31'd0, bus.req0_ready}, 32'd1);
        check("single_wait_grant", {30'd0, bus.grant}, 32'd1);
        wait_idle("single_idle");

        // Tie and fairness from reset.
        apply_reset("reset2");
        exp_q.push_back({2'b01, 8'h11});
        exp_q.push_back({2'b10, 8'h22});
        exp_q.push_back({2'b01, 8'h33});
        exp_q.push_back({2'b10, 8'h44});
        exp_q.push_back({2'b01, 8'h55});
        exp_q.push_back({2'b10, 8'h66});
        fork
            begin send(0, 8'h11); send(0, 8'h33); send(0, 8'h55); end
            begin send(1, 8'h22); send(1, 8'h44); send(1, 8'h66); end
        join
        wait_idle("fair_idle");

        // Stall with backpressure on the same port.
        bus.tx_ready = 1'b0;
        exp_q.push_back({2'b01, 8'h3C});
        send(0, 8'h3C);
        k = 0;
        while (bus.tx_valid !== 1'b1 && k < 40) begin
            @(posedge clk);
            #1 k++;
        end
        if (k >= 40) fail_now("stall_valid");
        for (int i = 0; i < 5; i++) begin
            if (i == 0) begin
                bus.req0_data  = 8'h02;
                bus.req0_valid = 1'b1;
            end
            @(negedge clk);
            check("stall_valid", {31'd0, bus.tx_valid}, 32'd1);
            check("stall_data", {24'd0, bus.tx_data}, 32'h3C);
            check("stall_grant", {30'd0, bus.grant}, 32'd1);
            check("stall_req0_ready", {31'd0, bus.req0_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        bus.req0_valid = 1'b0;
        bus.tx_ready   = 1'b1;
        wait_idle("stall_idle");

        // Gap: req1 pending when busy falls; held until two enable pulses after GAP entry.
        exp_q.push_back({2'b01, 8'h77});
        exp_q.push_back({2'b10, 8'h88});
        send(0, 8'h77);
        send(1, 8'h88);
        k = 0;
        while (bus.tx_busy !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        while (bus.tx_busy !== 1'b0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) fail_now("gap_busy");
        @(posedge clk);
        @(negedge clk);
        check("gap_grant_clear", {30'd0, bus.grant}, 32'd0);
        check("gap_busy_o", {31'd0, bus.busy}, 32'd1);
        pulses = 0;
        early  = 1'b0;
        k      = 0;
        while (pulses < 2 && k < 64) begin
            if (k > 0) @(negedge clk);
            if (bus.tx_valid === 1'b1) early = 1'b1;
            if (clk_en === 1'b1) pulses++;
            k++;
        end
        if (k >= 64) fail_now("gap_pulses");
        check("gap_no_early_tx", {31'd0, early}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("gap_idle_valid", {31'd0, bus.tx_valid}, 32'd0);
        check("gap_idle_busy", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        check("gap_next_valid", {31'd0, bus.tx_valid}, 32'd1);
        check("gap_next_grant", {30'd0, bus.grant}, 32'd2);
        wait_idle("gap_idle");

        // GAP_TICKS = 0 instance: valid two cycles after busy falls.
        bus0.req0_data  = 8'h5A;
        bus0.req0_valid = 1'b1;
        @(posedge clk);
        #1 bus0.req0_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("g0_first_valid", {31'd0, bus0.tx_valid}, 32'd1);
        check("g0_first_data", {24'd0, bus0.tx_data}, 32'h5A);
        @(posedge clk);
        #1 bus0.tx_busy = 1'b1;
        bus0.req0_data  = 8'h5B;
        bus0.req0_valid = 1'b1;
        @(posedge clk);
        #1 bus0.req0_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 bus0.tx_busy = 1'b0;
        @(negedge clk);
        check("g0_wait_valid", {31'd0, bus0.tx_valid}, 32'd0);
        @(negedge clk);
        check("g0_idle_valid", {31'd0, bus0.tx_valid}, 32'd0);
        check("g0_idle_busy", {31'd0, bus0.busy}, 32'd0);
        @(negedge clk);
        check("g0_next_valid", {31'd0, bus0.tx_valid}, 32'd1);
        check("g0_next_data", {24'd0, bus0.tx_data}, 32'h5B);
        check("g0_next_grant", {30'd0, bus0.grant}, 32'd1);
        @(posedge clk);
        #1;

        // Reset mid-frame with both holding registers full; nothing stale may follow.
        bus.tx_ready = 1'b0;
        fork
            send(0, 8'h9A);
            send(1, 8'h9B);
        join
        k = 0;
        while (bus.tx_valid !== 1'b1 && k < 40) begin
            @(posedge clk);
            #1 k++;
        end
        if (k >= 40) fail_now("rst_send");
        check("rst_full_ready", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
        apply_reset("rst_mid");
        bus.tx_ready = 1'b1;
        repeat (40) @(negedge clk);
        check("rst_after_valid", {31'd0, bus.tx_valid}, 32'd0);
        check("rst_after_busy", {31'd0, bus.busy}, 32'd0);

        check("queue_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog");
    end
endmodule
